sram_axi_arbiter_nport: RTL and testbench
=========================================

Name: sram_axi_arbiter_nport

Overview:
- Parametrised bridge from N SRAM-like masters to one AXI3 master port.
- Replaces the fixed two-way data-path combine plus the single-purpose AXI interface, so i-cache, d-cache and uncached paths share one block.
- Round-robin arbitration; one outstanding transaction at a time; single-beat transfers only.

Parameters:
- N_PORTS, 3, number of SRAM-like slave ports (2..8).
- ID_W, 4, AXI ID width; the granted port index is zero-extended into arid/awid/wid.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- s_req  in  N_PORTS  per-port request.
- s_wr  in  N_PORTS  per-port write flag.
- s_size  in  2*N_PORTS  per-port size: 0 byte, 1 half, 2 word.
- s_addr  in  32*N_PORTS  per-port byte address.
- s_wdata  in  32*N_PORTS  per-port write data.
- s_rdata  out  32  read data, shared; qualified by s_data_ok.
- s_addr_ok  out  N_PORTS  one-hot pulse: request accepted.
- s_data_ok  out  N_PORTS  one-hot pulse: read data valid or write complete.
- arid/araddr/arsize/arvalid  out  ID_W/32/3/1  AR channel. arlen=0 and arburst=1 are tied inside the block.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1.
- rready  out  1.
- awid/awaddr/awsize/awvalid  out  ID_W/32/3/1  AW channel.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1.
- wready  in  1.
- bid/bresp/bvalid  in  ID_W/2/1.
- bready  out  1.

Behaviour:
- Reset (aresetn=0 at a rising edge): FSM goes to IDLE and rr_ptr=N_PORTS-1. All valid/ready outputs, addr_ok and data_ok are 0. Latched address, data, size and port are 0.
- Reset mid-transaction abandons the transaction. The slave shares aresetn.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE:
  - Scan ports starting at rr_ptr+1 with modulo wrap. The first port with s_req=1 wins.
  - In the same cycle, assert s_addr_ok[win] combinationally. Latch wr, size, addr, wdata and the win index; set rr_ptr=win.
  - Next state is RD_ADDR if wr=0, otherwise WR_ADDR_DATA.
  - With no requests, stay in IDLE and emit no pulses.
- RD_ADDR: arvalid=1 holding the latched addr, arsize={0,size}, arid=win. Move to RD_DATA on arvalid&&arready.
- RD_DATA:
  - rready=1.
  - On rvalid&&rlast: drive s_rdata=rdata, pulse s_data_ok[win] for 1 cycle, go to IDLE.
  - rid is not checked.
- WR_ADDR_DATA:
  - awvalid and wvalid are raised together. Each drops independently after its own handshake (tracked by aw_done/w_done flags).
  - Move to WR_RESP when both are done, including the case where both handshakes happen in the same cycle.
  - wlast=1. wdata=latched wdata, unshifted.
- WR_RESP: bready=1. On bvalid, pulse s_data_ok[win] and go to IDLE.
- wstrb:
  - size 0: 4'b0001<<addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - size 3 is treated as size 2.
- Minimum latency: grant to data_ok is 2 cycles after the grant cycle with zero-wait AXI. The next grant is possible in the cycle after data_ok.
- Handshake stability: valid outputs and their payload stay stable until the handshake; no valid is withdrawn early.
- Requesters hold s_req until addr_ok. A dropped s_req is never granted later.
- s_rdata holds its last value between reads.
- Response codes are ignored.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- Defined: the IDLE scan always starts at port 0, so the lowest index wins. rr_ptr is not implemented.
- Undefined: round-robin as above.

Test Plan:
- Single read: port 1 reads addr 0x1FC0_0004, size 2, with arready delayed 3 cycles. Expect: s_addr_ok[1] pulses 1 cycle; araddr=0x1FC0_0004, arsize=2, arid=1, held 4 cycles. rdata=0xDEADBEEF then gives s_rdata=0xDEADBEEF with s_data_ok[1] for 1 cycle.
- Byte write: port 2 writes size 0 at addr 0x8000_0003, wdata 0x55000000. Expect wstrb=4'b1000, awsize=0, wlast=1. With wready on cycle 1 and awready on cycle 3, WR_RESP is entered only after cycle 3. bvalid then gives s_data_ok[2].
- Round-robin: ports 0, 1 and 2 all request continuously for 6 transactions. Expect grant order 0,1,2,0,1,2. With FIXED_PRIO_EN, expect 0 every time while s_req[0] stays high.
- Simultaneous AW/W handshake: awready=wready=1 in the same cycle. Expect exactly one AW and one W beat and a transition to WR_RESP the next cycle.
- Reset mid-read: deassert aresetn during RD_DATA. Expect all valids=0, no data_ok, IDLE after release, and the first grant goes to port 0.
- Half-word at addr 0x...2: expect wstrb=4'b1100. Size 3 gives 4'b1111 and arsize=2.

Source files
------------

// File: rtl/sram_axi_arbiter_nport.sv
// Bridges N SRAM-like masters onto one single-beat AXI3 master port, one transaction in flight.
// Round-robin grant by default; define FIXED_PRIO_EN to make the lowest requesting port always win.
module sram_axi_arbiter_nport #(
    parameter int N_PORTS = 3,
    parameter int ID_W    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [N_PORTS-1:0]    s_req,
    input  logic [N_PORTS-1:0]    s_wr,
    input  logic [2*N_PORTS-1:0]  s_size,
    input  logic [32*N_PORTS-1:0] s_addr,
    input  logic [32*N_PORTS-1:0] s_wdata,
    output logic [31:0]           s_rdata,
    output logic [N_PORTS-1:0]    s_addr_ok,
    output logic [N_PORTS-1:0]    s_data_ok,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ID_W-1:0]       awid,
    output logic [31:0]           awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_W-1:0]       wid,
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);
    localparam int PW = $clog2(N_PORTS);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] win_q, win_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [PW-1:0] scan_base;
    logic          grant;
    logic [PW-1:0] grant_idx;
    logic          unused_ok;

    // Response ids and codes carry no information for a single in-flight transaction.
    assign unused_ok = ^{rid, rresp, bid, bresp};

`ifdef FIXED_PRIO_EN
    assign scan_base = PW'(N_PORTS - 1);
`else
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    assign scan_base = rr_ptr_q;
`endif

    // Walk from the far end of the scan order so the first requester in order is written last.
    always_comb begin : scan
        int idx;
        idx       = 0;
        grant     = 1'b0;
        grant_idx = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            idx = int'(scan_base) + k;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (s_req[idx]) begin
                grant     = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    always_comb begin : fsm
        int  sel;
        logic aw_fin, w_fin;
        sel       = int'(grant_idx);
        aw_fin    = 1'b0;
        w_fin     = 1'b0;
        state_d   = state_q;
        win_d     = win_q;
        wr_d      = wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifndef FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        s_addr_ok = '0;
        s_data_ok = '0;
        s_rdata   = rdata_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    s_addr_ok[grant_idx] = 1'b1;
                    win_d   = grant_idx;
                    wr_d    = s_wr[sel];
                    size_d  = (s_size[sel*2 +: 2] == 2'd3) ? 2'd2 : s_size[sel*2 +: 2];
                    addr_d  = s_addr[sel*32 +: 32];
                    wdata_d = s_wdata[sel*32 +: 32];
`ifndef FIXED_PRIO_EN
                    rr_ptr_d = grant_idx;
`endif
                    state_d = s_wr[sel] ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    s_rdata          = rdata;
                    rdata_d          = rdata;
                    s_data_ok[win_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            WR_ADDR_DATA: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                aw_fin  = aw_done_q || (awvalid && awready);
                w_fin   = w_done_q || (wvalid && wready);
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    s_data_ok[win_q] = 1'b1;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            win_q     <= '0;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef FIXED_PRIO_EN
            rr_ptr_q  <= PW'(N_PORTS - 1);
`endif
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifndef FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    // Size is normalised at grant, so only byte and half-word need lane selection.
    always_comb begin
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign araddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign arid   = ID_W'(win_q);
    assign awaddr = addr_q;
    assign awsize = {1'b0, size_q};
    assign awid   = ID_W'(win_q);
    assign wid    = ID_W'(win_q);
    assign wdata  = wdata_q;
    assign wlast  = 1'b1;
endmodule

// File: tb/tb_sram_axi_arbiter_nport.sv
// Random SRAM-side traffic against a queue-based reference of the arbiter and a randomly stalling AXI slave.
module tb_sram_axi_arbiter_nport;
    localparam int N  = 3;
    localparam int IW = 4;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic [N-1:0]    s_req, s_wr;
    logic [2*N-1:0]  s_size;
    logic [32*N-1:0] s_addr, s_wdata;
    logic [31:0]     s_rdata;
    logic [N-1:0]    s_addr_ok, s_data_ok;
    logic [IW-1:0]   arid, rid, awid, wid, bid;
    logic [31:0]     araddr, rdata, awaddr, wdata;
    logic [2:0]      arsize, awsize;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]      rresp, bresp;
    logic [3:0]      wstrb;

    always #5 aclk = ~aclk;

    sram_axi_arbiter_nport #(.N_PORTS(N), .ID_W(IW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr;
    bit   slow_r = 0;
    bit   gen_en = 0;
    int   maxgap = 0;
    bit   pend[N];
    int   gap[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte lanes covered by an access: naturally aligned block of 1, 2 or 4 bytes.
    function automatic logic [3:0] ref_strb(input logic [1:0] sz, input logic [1:0] a);
        int bytes, lo;
        logic [3:0] m;
        bytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        lo    = (int'(a) / bytes) * bytes;
        m     = '0;
        for (int b = 0; b < 4; b++) if (b >= lo && b < lo + bytes) m[b] = 1'b1;
        return m;
    endfunction

    // ---------------- monitor + AXI slave model ----------------
    initial begin : mon
        int r_cnt, b_cnt, stall, win, idx;
        bit ar_seen, aw_seen, w_seen, rst_applied, busy, rd, wrt, both;
        logic [31:0] rdata_cur, last_rdata, exp_rd;
        logic [N-1:0] exp_ok, exp_dok;
        txn_t t, nt;
        r_cnt = -1; b_cnt = -1; stall = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
        rst_applied = 0; rdata_cur = '0; last_rdata = '0; m_ptr = N - 1;
        t = '{0, 0, '0, '0, '0, '0};
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = '0; rid = '0; rresp = '0; rlast = 1'b1; bid = '0; bresp = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                if (rst_applied) begin
                    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
                    chk("rst_addr_ok", s_addr_ok, 0);
                    chk("rst_data_ok", s_data_ok, 0);
                end
                exp_q.delete();
                ar_seen = 0; aw_seen = 0; w_seen = 0; r_cnt = -1; b_cnt = -1;
                m_ptr = N - 1; last_rdata = '0; stall = 0; rst_applied = 1;
            end else begin
                rst_applied = 0;
                busy = (exp_q.size() != 0);
                if (busy) t = exp_q[0];
                rd  = busy && !t.wr;
                wrt = busy && t.wr;
                chk("arvalid", arvalid, rd && !ar_seen);
                chk("rready", rready, rd && ar_seen);
                chk("awvalid", awvalid, wrt && !aw_seen);
                chk("wvalid", wvalid, wrt && !w_seen);
                chk("bready", bready, wrt && aw_seen && w_seen);
                if (rd && arvalid) begin
                    chk("araddr", araddr, t.addr);
                    chk("arsize", arsize, {1'b0, t.size});
                    chk("arid", arid, t.port);
                end
                if (wrt && awvalid) begin
                    chk("awaddr", awaddr, t.addr);
                    chk("awsize", awsize, {1'b0, t.size});
                    chk("awid", awid, t.port);
                end
                if (wrt && wvalid) begin
                    chk("wdata", wdata, t.wdata);
                    chk("wstrb", wstrb, t.strb);
                    chk("wid", wid, t.port);
                    chk("wlast", wlast, 1);
                end
                exp_dok = '0;
                exp_rd  = last_rdata;
                if (busy && rvalid) begin
                    exp_dok[t.port] = 1'b1;
                    exp_rd     = rdata_cur;
                    last_rdata = rdata_cur;
                end else if (busy && bvalid) begin
                    exp_dok[t.port] = 1'b1;
                end
                chk("data_ok", s_data_ok, exp_dok);
                chk("s_rdata", s_rdata, exp_rd);
                if (busy && (rvalid || bvalid)) begin
                    void'(exp_q.pop_front());
                    ar_seen = 0; aw_seen = 0; w_seen = 0;
                end else begin
                    if (rd && !ar_seen && arvalid && arready) begin
                        ar_seen = 1;
                        r_cnt = slow_r ? 20 : $urandom_range(0, 3);
                    end
                    both = aw_seen && w_seen;
                    if (wrt && !aw_seen && awvalid && awready) aw_seen = 1;
                    if (wrt && !w_seen && wvalid && wready) w_seen = 1;
                    if (wrt && !both && aw_seen && w_seen) b_cnt = $urandom_range(0, 3);
                end
                exp_ok = '0;
                win = -1;
                if (!busy) begin
                    for (int k = 1; k <= N; k++) begin
`ifdef FIXED_PRIO_EN
                        idx = k - 1;
`else
                        idx = (m_ptr + k) % N;
`endif
                        if (win < 0 && s_req[idx]) win = idx;
                    end
                end
                if (win >= 0) exp_ok[win] = 1'b1;
                chk("addr_ok", s_addr_ok, exp_ok);
                if (win >= 0) begin
                    nt.port  = win;
                    nt.wr    = s_wr[win];
                    nt.addr  = s_addr[32*win +: 32];
                    nt.size  = (s_size[2*win +: 2] == 2'd3) ? 2'd2 : s_size[2*win +: 2];
                    nt.wdata = s_wdata[32*win +: 32];
                    nt.strb  = ref_strb(nt.size, nt.addr[1:0]);
                    exp_q.push_back(nt);
                    m_ptr = win;
                end
                if ((busy || s_req != 0) && s_addr_ok == 0 && s_data_ok == 0) stall++;
                else stall = 0;
                if (stall > 400) begin
                    checks++; errors++;
                    $display("FAIL watchdog: got no progress for %0d cycles expected progress", stall);
                    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                    $finish;
                end
            end
            @(posedge aclk);
            #1;
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
            rdata   = $urandom;
            rid     = IW'($urandom);
            rresp   = 2'($urandom);
            bid     = IW'($urandom);
            bresp   = 2'($urandom);
            rvalid  = 0;
            bvalid  = 0;
            if (r_cnt == 0) begin
                rvalid = 1; rdata_cur = rdata; r_cnt = -1;
            end else if (r_cnt > 0) r_cnt--;
            if (b_cnt == 0) begin
                bvalid = 1; b_cnt = -1;
            end else if (b_cnt > 0) b_cnt--;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input int p, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        s_wr[p]            = wr;
        s_size[2*p +: 2]   = sz;
        s_addr[32*p +: 32] = a;
        s_wdata[32*p +: 32] = d;
        s_req[p]           = 1'b1;
    endtask

    task automatic cycle();
        @(negedge aclk);
        if (aresetn) begin
            for (int p = 0; p < N; p++) begin
                if (s_req[p] && s_addr_ok[p]) pend[p] = 1;
                else if (pend[p] && s_data_ok[p]) begin
                    pend[p] = 0;
                    gap[p]  = $urandom_range(0, maxgap);
                end
            end
        end
        @(posedge aclk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (s_req[p] && pend[p]) s_req[p] = 1'b0;
            else if (gen_en && !s_req[p] && !pend[p]) begin
                if (gap[p] > 0) gap[p]--;
                else issue(p, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            end
        end
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            cycle();
            done = (s_req == 0);
            for (int p = 0; p < N; p++) if (pend[p]) done = 0;
        end
        chk(name, done, 1);
    endtask

    initial begin : main
        bit reached;
        aresetn = 0; s_req = '0; s_wr = '0; s_size = '0; s_addr = '0; s_wdata = '0;
        for (int p = 0; p < N; p++) begin pend[p] = 0; gap[p] = 0; end
        repeat (3) cycle();
        aresetn = 1;
        issue(1, 0, 2'd2, 32'h1FC0_0004, 32'h0);
        drain("drain_read_word");
        issue(2, 1, 2'd0, 32'h8000_0003, 32'h5500_0000);
        drain("drain_write_byte");
        issue(0, 1, 2'd1, 32'h0000_1002, 32'hAABB_CCDD);
        drain("drain_write_half");
        issue(1, 1, 2'd3, 32'h0000_0011, 32'h1234_5678);
        drain("drain_write_size3");
        issue(0, 0, 2'd3, 32'h0000_0020, 32'h0);
        issue(1, 0, 2'd2, 32'h0000_0024, 32'h0);
        issue(2, 0, 2'd1, 32'h0000_0026, 32'h0);
        drain("drain_three_way");
        gen_en = 1; maxgap = 0;
        repeat (400) cycle();
        maxgap = 4;
        repeat (2500) cycle();
        gen_en = 0;
        drain("drain_random");
        slow_r = 1;
        issue(2, 0, 2'd2, 32'h0000_0100, 32'h0);
        reached = 0;
        for (int i = 0; i < 60 && !reached; i++) begin
            cycle();
            reached = rready;
        end
        chk("mid_read_reached", reached, 1);
        aresetn = 0;
        s_req   = '0;
        for (int p = 0; p < N; p++) pend[p] = 0;
        repeat (3) cycle();
        aresetn = 1;
        slow_r  = 0;
        issue(0, 0, 2'd2, 32'h0000_0200, 32'h0);
        issue(1, 0, 2'd2, 32'h0000_0204, 32'h0);
        issue(2, 0, 2'd2, 32'h0000_0208, 32'h0);
        drain("drain_after_reset");
        repeat (3) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
